// File: rtl/fpga_scan_pkg.sv
// fpga_scan_pkg: shared constants and types for the fabric scan chain.
package fpga_scan_pkg;
    localparam int SCAN_CHAIN_LEN_DEFAULT = 1024;
    typedef logic [$clog2(SCAN_CHAIN_LEN_DEFAULT)-1:0] stage_idx_t;
endpackage

// File: rtl/scff_cell.sv
// scff_cell: one mux-D scan flop, scan input in shift mode, functional input otherwise.
module scff_cell (
    input  logic op_clk,
    input  logic Reset,
    input  logic Test_en,
    input  logic scan_in,
    input  logic func_in,
    output logic q
);
    always_ff @(posedge op_clk or posedge Reset) begin
        if (Reset) q <= 1'b0;
        else       q <= Test_en ? scan_in : func_in;
    end
endmodule

// File: rtl/fpga_scan_chain.sv
// fpga_scan_chain: serial/parallel scan-flop chain between sc_head and sc_tail.
module fpga_scan_chain
    import fpga_scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN_DEFAULT
) (
    input  logic                 op_clk,
    input  logic                 Reset,
    input  logic                 Test_en,
    input  logic                 IO_ISOL_N,
    input  logic                 sc_head,
    input  logic [CHAIN_LEN-1:0] func_d,
    output logic                 sc_tail,
    output logic [CHAIN_LEN-1:0] func_q
);
    logic [CHAIN_LEN-1:0] q;
    logic [CHAIN_LEN-1:0] scan_vec;
    assign scan_vec = {q[CHAIN_LEN-2:0], sc_head};
    for (genvar g = 0; g < CHAIN_LEN; g++) begin : g_cell
        scff_cell u_cell (
            .op_clk (op_clk),
            .Reset  (Reset),
            .Test_en(Test_en),
            .scan_in(scan_vec[g]),
            .func_in(func_d[g]),
            .q      (q[g])
        );
    end
    // scan unload must keep working while the fabric is isolated
    assign sc_tail = q[CHAIN_LEN-1];
    assign func_q  = IO_ISOL_N ? q : '0;
endmodule

// File: tb/tb_fpga_scan_chain.sv
// tb_fpga_scan_chain: model-checked directed bench for the 1024-stage scan chain.
module tb_fpga_scan_chain;
    localparam int N = 1024;
    logic op_clk = 1'b0;
    logic Reset = 1'b1;
    logic Test_en = 1'b1;
    logic IO_ISOL_N = 1'b1;
    logic sc_head = 1'b0;
    logic [N-1:0] func_d = '0;
    logic sc_tail;
    logic [N-1:0] func_q;
    logic [N-1:0] m = '0;
    logic [N-1:0] pat;
    int n_chk = 0;
    int n_pass = 0;

    fpga_scan_chain #(.CHAIN_LEN(N)) dut (
        .op_clk(op_clk), .Reset(Reset), .Test_en(Test_en), .IO_ISOL_N(IO_ISOL_N),
        .sc_head(sc_head), .func_d(func_d), .sc_tail(sc_tail), .func_q(func_q)
    );

    always #5 op_clk = ~op_clk;

    // reference: in shift mode each stage takes its predecessor's old value, else the capture word
    always @(posedge op_clk or posedge Reset) begin
        if (Reset) m <= '0;
        else if (Test_en) m <= {m[N-2:0], sc_head};
        else m <= func_d;
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got low128=%h expected low128=%h", name, act[127:0], exp[127:0]);
    endtask

    always @(posedge op_clk) begin
        #1;
        chk("model_tail", {{(N-1){1'b0}}, sc_tail}, {{(N-1){1'b0}}, m[N-1]});
        chk("model_funcq", func_q, IO_ISOL_N ? m : '0);
    end

    task automatic step();
        @(posedge op_clk);
        #3;
    endtask

    task automatic rand_fd();
        for (int w = 0; w < N / 32; w++) func_d[w*32 +: 32] = $urandom;
    endtask

    initial begin
        step();
        step();
        Reset = 1'b0;
        // reset: random load, then asynchronous reset mid-cycle
        Test_en = 1'b0;
        rand_fd();
        step();
        Reset = 1'b1;
        #1;
        chk("rst_tail_async", {{(N-1){1'b0}}, sc_tail}, '0);
        chk("rst_funcq_async", func_q, '0);
        @(negedge op_clk);
        Reset = 1'b0;
        Test_en = 1'b1;
        sc_head = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step();
            chk("rst_tail_after", {{(N-1){1'b0}}, sc_tail}, '0);
            chk("rst_funcq_after", func_q, '0);
        end
        // single-pulse latency
        for (int e = 1; e <= N + 3; e++) begin
            sc_head = (e == 1);
            step();
            if (e >= N - 1) chk("pulse_tail", {{(N-1){1'b0}}, sc_tail}, {{(N-1){1'b0}}, e == N});
        end
        // pattern flush: edge e shifts pat[N-e], so stage i ends holding pat[i]
        pat = {(N / 8){8'hA5}};
        for (int e = 1; e <= N; e++) begin
            sc_head = pat[N-e];
            step();
        end
        chk("pattern_funcq", func_q, pat);
        sc_head = 1'b0;
        for (int j = 0; j < N; j++) begin
            chk("pattern_unload", {{(N-1){1'b0}}, sc_tail}, {{(N-1){1'b0}}, pat[N-1-j]});
            step();
        end
        // capture then unload
        pat = {(N / 32){32'hDEADBEEF}};
        func_d = pat;
        Test_en = 1'b0;
        step();
        chk("capture_funcq", func_q, pat);
        Test_en = 1'b1;
        rand_fd();
        for (int j = 0; j < 16; j++) begin
            chk("capture_unload", {{(N-1){1'b0}}, sc_tail}, {{(N-1){1'b0}}, pat[N-1-j]});
            step();
        end
        // isolation gates func_q but not sc_tail
        func_d = '1;
        Test_en = 1'b0;
        step();
        IO_ISOL_N = 1'b0;
        #1;
        chk("isol_funcq", func_q, '0);
        chk("isol_tail", {{(N-1){1'b0}}, sc_tail}, {{(N-1){1'b0}}, 1'b1});
        IO_ISOL_N = 1'b1;
        #1;
        chk("unisol_funcq", func_q, '1);
        // mode switching every 4 edges
        for (int e = 0; e < 64; e++) begin
            Test_en = ((e / 4) % 2) == 0;
            sc_head = 1'($urandom);
            rand_fd();
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
